// File: rtl/demux32_1to2_buf.sv
// Buffered 1-to-2 demultiplexer: one valid/ready input stream steered to port A or B, each with a 2-entry FIFO.
// Optional per-port accept counters are built only when DEMUX_STATS_EN is defined.

module demux32_1to2_buf_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             pop;

  assign pop     = (occ_q != 2'd0) && ready_i;
  assign valid_o = (occ_q != 2'd0);
  assign data_o  = head_q;
  assign full_o  = (occ_q == 2'd2);

  // head_q is the visible word; it is left untouched when the FIFO drains so the
  // output keeps its last value.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push_i, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = wr_data_i;
          occ_d  = 2'd1;
        end else if (occ_q == 2'd1) begin
          tail_d = wr_data_i;
          occ_d  = 2'd2;
        end
      end
      2'b01: begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
        end
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = wr_data_i;
        end else begin
          head_d = tail_q;
          tail_d = wr_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

module demux32_1to2_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  // Index 0 is port A (in_sel=1), index 1 is port B (in_sel=0).
  logic             push  [2];
  logic             rdy   [2];
  logic             vld   [2];
  logic [WIDTH-1:0] dat   [2];
  logic             full  [2];
  logic             accept;

  // Only the selected port's fullness gates the input, so a full port blocks the
  // stream even when the other side is idle.
  assign in_ready = in_sel ? !full[0] : !full[1];
  assign accept   = in_valid && in_ready;

  assign push[0] = accept && in_sel;
  assign push[1] = accept && !in_sel;
  assign rdy[0]  = a_ready;
  assign rdy[1]  = b_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      demux32_1to2_buf_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .push_i    (push[gi]),
        .wr_data_i (in_data),
        .ready_i   (rdy[gi]),
        .valid_o   (vld[gi]),
        .data_o    (dat[gi]),
        .full_o    (full[gi])
      );
    end
  endgenerate

  assign a_valid = vld[0];
  assign a_data  = dat[0];
  assign b_valid = vld[1];
  assign b_data  = dat[1];

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  // Clear first, then count, so clear plus accept leaves exactly 1 in the target.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (stats_clr) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
    end
    if (push[0]) cnt_a_d = cnt_a_d + 1'b1;
    if (push[1]) cnt_b_d = cnt_b_d + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign cnt_a = '0;
  assign cnt_b = '0;
`endif

endmodule

// File: tb/tb_demux32_1to2_buf.sv
// Bench for demux32_1to2_buf: directed scenarios plus a random phase, checked against a queue-based model.
module tb_demux32_1to2_buf;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             Clk;
  logic             Reset_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic             stats_clr;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  demux32_1to2_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .stats_clr (stats_clr),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int passed = 0;
  int total  = 0;

  // Reference model: one queue per port, last-shown word per port, counters.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] exp_ad, exp_bd;
  int          exp_ca, exp_cb;
  logic        last_stall;
  logic        last_s;
  logic [31:0] last_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    exp_ad = '0;
    exp_bd = '0;
    exp_ca = 0;
    exp_cb = 0;
    last_stall = 1'b0;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ":a_valid"}, 32'(a_valid), 32'(qa.size() != 0));
    chk({ph, ":a_data"},  a_data, exp_ad);
    chk({ph, ":b_valid"}, 32'(b_valid), 32'(qb.size() != 0));
    chk({ph, ":b_data"},  b_data, exp_bd);
`ifdef DEMUX_STATS_EN
    chk({ph, ":cnt_a"}, 32'(cnt_a), 32'(exp_ca));
    chk({ph, ":cnt_b"}, 32'(cnt_b), 32'(exp_cb));
`else
    chk({ph, ":cnt_a"}, 32'(cnt_a), 32'd0);
    chk({ph, ":cnt_b"}, 32'(cnt_b), 32'd0);
`endif
  endtask

  // One clock cycle: drive at negedge, check in_ready, apply the edge to the model, check outputs.
  task automatic step(input string ph, input logic v, input logic s, input logic [31:0] d,
                      input logic ar, input logic br, input logic clr);
    logic exp_rdy;
    logic acc;
    logic pop_a;
    logic pop_b;
    @(negedge Clk);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    a_ready   = ar;
    b_ready   = br;
    stats_clr = clr;
    #1;
    exp_rdy = ((s ? qa.size() : qb.size()) != 2);
    chk({ph, ":in_ready"}, 32'(in_ready), 32'(exp_rdy));
    acc   = v && exp_rdy;
    pop_a = (qa.size() != 0) && ar;
    pop_b = (qb.size() != 0) && br;
    @(posedge Clk);
    if (pop_a) void'(qa.pop_front());
    if (pop_b) void'(qb.pop_front());
    if (acc) begin
      if (s) qa.push_back(d);
      else   qb.push_back(d);
    end
    if (clr) begin
      exp_ca = 0;
      exp_cb = 0;
    end
    if (acc) begin
      if (s) exp_ca = (exp_ca + 1) % (1 << CNT_W);
      else   exp_cb = (exp_cb + 1) % (1 << CNT_W);
    end
    if (qa.size() != 0) exp_ad = qa[0];
    if (qb.size() != 0) exp_bd = qb[0];
    last_stall = v && !exp_rdy;
    last_s     = s;
    last_d     = d;
    $display("[%0t] %s v=%0d sel=%0d data=%h acc=%0d popA=%0d popB=%0d occA=%0d occB=%0d",
             $time, ph, v, s, d, acc, pop_a, pop_b, qa.size(), qb.size());
    #1;
    check_outputs(ph);
  endtask

  // Reset asserted between edges; outputs must clear without any clock edge.
  task automatic async_reset(input string ph);
    @(negedge Clk);
    in_valid  = 1'b0;
    stats_clr = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    chk({ph, ":in_ready"}, 32'(in_ready), 32'd1);
    check_outputs(ph);
    $display("[%0t] %s reset asserted", $time, ph);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // Upstream must hold in_data/in_sel while stalled; the bench's own driver obeys this.
  logic        p_stall = 1'b0;
  logic        p_sel   = 1'b0;
  logic [31:0] p_data  = '0;
  always @(posedge Clk) begin
    if (p_stall && in_valid && Reset_n)
      assert (in_sel === p_sel && in_data === p_data)
      else $error("FAIL upstream_hold: sel %0d data %h held %0d %h", in_sel, in_data, p_sel, p_data);
    p_stall <= in_valid && !in_ready && Reset_n;
    p_sel   <= in_sel;
    p_data  <= in_data;
  end

  initial begin
    logic        rv, rs, rar, rbr, rclr;
    logic [31:0] rd;
    Reset_n   = 1'b1;
    in_data   = '0;
    in_sel    = 1'b0;
    in_valid  = 1'b0;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    stats_clr = 1'b0;
    model_reset();

    async_reset("t1_reset");

    step("t2_pushA", 1'b1, 1'b1, 32'h11111111, 1'b1, 1'b1, 1'b0);
    step("t2_pushB", 1'b1, 1'b0, 32'h22222222, 1'b1, 1'b1, 1'b0);
    step("t2_drain", 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0);
    step("t2_idle",  1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0);

    step("t3_A0",    1'b1, 1'b1, 32'hA0, 1'b0, 1'b1, 1'b0);
    step("t3_A1",    1'b1, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b0);
    step("t3_probeB",1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0);
    step("t3_A2st",  1'b1, 1'b1, 32'hA2, 1'b0, 1'b1, 1'b0);
    step("t3_A2pop", 1'b1, 1'b1, 32'hA2, 1'b1, 1'b1, 1'b0);
    step("t3_A2acc", 1'b1, 1'b1, 32'hA2, 1'b1, 1'b1, 1'b0);
    step("t3_drain", 1'b0, 1'b1, 32'h0,  1'b1, 1'b1, 1'b0);
    step("t3_idle",  1'b0, 1'b1, 32'h0,  1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++)
      step("t4_stream", 1'b1, 1'b1, 32'hC000_0000 + 32'(i), 1'b1, 1'b1, 1'b0);
    step("t4_drain", 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);

    step("t5_fillA0", 1'b1, 1'b1, 32'hDEAD0001, 1'b0, 1'b0, 1'b0);
    step("t5_fillA1", 1'b1, 1'b1, 32'hDEAD0002, 1'b0, 1'b0, 1'b0);
    step("t5_fillB0", 1'b1, 1'b0, 32'hBEEF0001, 1'b0, 1'b0, 1'b0);
    step("t5_fillB1", 1'b1, 1'b0, 32'hBEEF0002, 1'b0, 1'b0, 1'b0);
    async_reset("t5_reset");
    for (int i = 0; i < 3; i++)
      step("t5_after", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++)
      step("t6_cntB", 1'b1, 1'b0, 32'hB000_0000 + 32'(i), 1'b1, 1'b1, 1'b0);
    step("t6_clr_accA", 1'b1, 1'b1, 32'h5555AAAA, 1'b1, 1'b1, 1'b1);
    step("t6_idle",     1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++) begin
      if (last_stall) begin
        rv = 1'b1;
        rs = last_s;
        rd = last_d;
      end else begin
        rv = ($urandom_range(0, 3) != 0);
        rs = 1'($urandom_range(0, 1));
        rd = $urandom;
      end
      rar  = ($urandom_range(0, 2) != 0);
      rbr  = ($urandom_range(0, 2) == 0);
      rclr = ($urandom_range(0, 15) == 0);
      step("rand", rv, rs, rd, rar, rbr, rclr);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
